// File: rtl/spiflash_rd_pkg.sv
// -----------------------------------------------------------------------------
// spiflash_rd_pkg
// Shared definitions for the SPI flash read controller:
//   - state_e   : controller state encoding (IDLE/CMD/ADDR/DATA/GAP)
//   - CMD_READ  : standard SPI "read data" opcode
//   - CMD_BITS / ADDR_END / DATA_END : bit-index boundaries within one
//     64-bit transaction (8 command bits, 24 address bits, 32 data bits)
//   - drives_io0() : true in the states where the controller owns io0
// -----------------------------------------------------------------------------
package spiflash_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  localparam logic [7:0] CMD_READ = 8'h03;

  // Bit boundaries, counted from the first SCK period of a transaction.
  localparam int unsigned CMD_BITS = 8;   // bits 0..7   : opcode
  localparam int unsigned ADDR_END = 32;  // bits 8..31  : address
  localparam int unsigned DATA_END = 64;  // bits 32..63 : read data

  // io0 is only driven while the opcode and address are going out.
  function automatic logic drives_io0(input logic [2:0] st);
    return (st == ST_CMD) || (st == ST_ADDR);
  endfunction

endpackage : spiflash_rd_pkg

// File: rtl/spiflash_rd_sckgen.sv
// -----------------------------------------------------------------------------
// spiflash_rd_sckgen
// SPI mode-0 clock generator. Each SCK half-period lasts CLK_DIV core_clk
// cycles, starting with the low half. While flash_csb is high the divider is
// held cleared and SCK is parked low, so every transaction starts with a full
// low half-period.
//
// Ports:
//   core_clk   in   core clock (rising edge)
//   core_rstn  in   asynchronous active-low reset
//   flash_csb  in   chip select; divider runs only while it is low
//   sck        out  SPI clock (registered)
//   rise_stb   out  high for the single core_clk cycle whose rising edge
//                   takes sck from 0 to 1
//   fall_stb   out  high for the single core_clk cycle whose rising edge
//                   takes sck from 1 to 0
// -----------------------------------------------------------------------------
module spiflash_rd_sckgen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic core_clk,
  input  logic core_rstn,
  input  logic flash_csb,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] div_cnt_reg;
  logic [7:0] div_cnt_next;
  logic       sck_reg;
  logic       sck_next;
  logic       run;
  logic       half_done;

  assign run       = !flash_csb;
  assign half_done = run && (div_cnt_reg == 8'(CLK_DIV - 1));

  always_comb begin
    div_cnt_next = div_cnt_reg;
    sck_next     = sck_reg;
    if (!run) begin
      div_cnt_next = '0;
      sck_next     = 1'b0;
    end else if (half_done) begin
      div_cnt_next = '0;
      sck_next     = !sck_reg;
    end else begin
      div_cnt_next = div_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      sck_reg     <= sck_next;
    end
  end

  // Strobes announce the edge that the register is about to take.
  assign rise_stb = half_done && !sck_reg;
  assign fall_stb = half_done &&  sck_reg;
  assign sck      = sck_reg;

endmodule : spiflash_rd_sckgen

// File: rtl/spiflash_rd_ctrl.sv
// -----------------------------------------------------------------------------
// spiflash_rd_ctrl
// Single-word SPI flash read controller. Each accepted request issues opcode
// 0x03 plus a 24-bit address on io0 (MSB first), then clocks in 32 bits on
// io1 and returns them as a little-endian word (first received byte in
// rsp_data[7:0]). One transaction is exactly 64 SCK periods, i.e.
// 128*CLK_DIV core cycles of flash_csb low, followed by CSB_GAP cycles in GAP
// before the controller is ready again.
//
// Ports:
//   core_clk       in   core clock (rising edge)
//   core_rstn      in   asynchronous active-low reset
//   req_valid      in   read request strobe
//   req_ready      out  high only in IDLE (low while reset is asserted)
//   req_addr[23:0] in   flash byte address, captured on accept
//   rsp_valid      out  one-cycle pulse, coincident with flash_csb rising
//   rsp_data[31:0] out  assembled word, held until the next rsp_valid
//   flash_csb      out  chip select, active low
//   flash_clk      out  SPI clock, mode 0
//   flash_io0_do   out  MOSI
//   flash_io0_oeb  out  io0 output enable, active low
//   flash_io1_di   in   MISO
// -----------------------------------------------------------------------------
module spiflash_rd_ctrl
  import spiflash_rd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CSB_GAP = 2
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_do,
  output logic        flash_io0_oeb,
  input  logic        flash_io1_di
);

  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] CMD  = ST_CMD;
  localparam logic [2:0] ADDR = ST_ADDR;
  localparam logic [2:0] DATA = ST_DATA;
  localparam logic [2:0] GAP  = ST_GAP;

  localparam logic [5:0] CMD_LAST  = 6'(CMD_BITS - 1);
  localparam logic [5:0] ADDR_LAST = 6'(ADDR_END - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_END - 1);

  logic [2:0]  state_reg,    state_next;
  logic [5:0]  bit_cnt_reg,  bit_cnt_next;
  logic [3:0]  gap_cnt_reg,  gap_cnt_next;
  logic [31:0] tx_sr_reg,    tx_sr_next;
  logic [31:0] rx_sr_reg,    rx_sr_next;
  logic [31:0] rsp_data_reg, rsp_data_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        csb_reg,      csb_next;
  logic        ready_reg,    ready_next;

  logic        sck_rise;
  logic        sck_fall;
  logic        accept;
  logic [31:0] rx_le;

  // ---------------------------------------------------------------------------
  // SCK generation; idle whenever chip select is deasserted.
  // ---------------------------------------------------------------------------
  spiflash_rd_sckgen #(
    .CLK_DIV (CLK_DIV)
  ) u_sckgen (
    .core_clk  (core_clk),
    .core_rstn (core_rstn),
    .flash_csb (csb_reg),
    .sck       (flash_clk),
    .rise_stb  (sck_rise),
    .fall_stb  (sck_fall)
  );

  // ---------------------------------------------------------------------------
  // Byte reordering: bytes arrive MSB-first into rx_sr_reg, so the first
  // received byte ends up in rx_sr_reg[31:24]; it belongs in rsp_data[7:0].
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_swap
    assign rx_le[8*gi +: 8] = rx_sr_reg[31 - 8*gi -: 8];
  end

  // ready_reg is only ever set when the next state is IDLE.
  assign accept = req_valid && ready_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    tx_sr_next     = tx_sr_reg;
    rx_sr_next     = rx_sr_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_valid_next = 1'b0;
    csb_next       = csb_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = CMD;
          csb_next     = 1'b0;
          bit_cnt_next = '0;
          // First opcode bit is presented together with chip select, giving
          // it a full low half-period of setup before the first rising edge.
          tx_sr_next   = {CMD_READ, req_addr};
        end
      end

      CMD, ADDR, DATA: begin
        if (sck_rise && (state_reg == DATA)) begin
          rx_sr_next = {rx_sr_reg[30:0], flash_io1_di};
        end
        if (sck_fall) begin
          // io0 only changes on the falling edge; zeros are shifted in, so
          // io0 rests at 0 once the address has gone out.
          tx_sr_next   = {tx_sr_reg[30:0], 1'b0};
          bit_cnt_next = bit_cnt_reg + 6'd1;
          if (bit_cnt_reg == CMD_LAST) begin
            state_next = ADDR;
          end
          if (bit_cnt_reg == ADDR_LAST) begin
            state_next = DATA;
          end
          if (bit_cnt_reg == DATA_LAST) begin
            state_next     = GAP;
            csb_next       = 1'b1;
            rsp_valid_next = 1'b1;
            rsp_data_next  = rx_le;
            gap_cnt_next   = 4'(CSB_GAP - 1);
          end
        end
      end

      GAP: begin
        if (gap_cnt_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
        csb_next   = 1'b1;
      end
    endcase

    // Registered so that ready stays low during reset and rises on the
    // first edge after release.
    ready_next = (state_next == IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      tx_sr_reg     <= '0;
      rx_sr_reg     <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      csb_reg       <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      tx_sr_reg     <= tx_sr_next;
      rx_sr_reg     <= rx_sr_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_valid_reg <= rsp_valid_next;
      csb_reg       <= csb_next;
      ready_reg     <= ready_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready     = ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_data      = rsp_data_reg;
  assign flash_csb     = csb_reg;
  assign flash_io0_do  = tx_sr_reg[31];
  assign flash_io0_oeb = !drives_io0(state_reg);

endmodule : spiflash_rd_ctrl

// File: tb/tb_spiflash_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spiflash_rd_ctrl
// Two controller instances share clock and reset: g_inst[0] with CLK_DIV=2 and
// g_inst[1] with CLK_DIV=1, both with CSB_GAP=3. Each has its own behavioural
// SPI flash model (mode 0, command 0x03, auto-incrementing 24-bit address)
// reading from one shared sparse memory.
// -----------------------------------------------------------------------------
module tb_spiflash_rd_ctrl;

  localparam int GAP = 3;

  logic        core_clk = 1'b0;
  logic        core_rstn;
  logic        req_valid [2];
  logic [23:0] req_addr  [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic        csb       [2];
  logic        fclk      [2];
  logic        io0_do    [2];
  logic        io0_oeb   [2];
  logic        io1       [2];

  logic [7:0]  mem [logic [23:0]];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 core_clk = ~core_clk;

  function automatic logic mem_bit(input logic [23:0] a, input int unsigned j);
    logic [23:0] ba;
    logic [7:0]  b;
    ba = a + 24'(j / 8);
    b  = mem.exists(ba) ? mem[ba] : 8'h00;
    return b[7 - (j % 8)];
  endfunction

  // ---------------------------------------------------------------------------
  // DUT instances and flash models
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int D = (gi == 0) ? 2 : 1;

    int unsigned m_cnt     = 0;
    int unsigned m_oeb_bad = 0;
    int unsigned m_rsp     = 0;
    logic [31:0] m_hdr     = '0;
    logic        m_do      = 1'b0;

    spiflash_rd_ctrl #(
      .CLK_DIV (D),
      .CSB_GAP (GAP)
    ) u_dut (
      .core_clk      (core_clk),
      .core_rstn     (core_rstn),
      .req_valid     (req_valid[gi]),
      .req_ready     (req_ready[gi]),
      .req_addr      (req_addr[gi]),
      .rsp_valid     (rsp_valid[gi]),
      .rsp_data      (rsp_data[gi]),
      .flash_csb     (csb[gi]),
      .flash_clk     (fclk[gi]),
      .flash_io0_do  (io0_do[gi]),
      .flash_io0_oeb (io0_oeb[gi]),
      .flash_io1_di  (io1[gi])
    );

    assign io1[gi] = m_do;

    // Flash samples io0 on SCK rising edges: 8 opcode + 24 address bits.
    always @(posedge fclk[gi] or posedge csb[gi]) begin
      if (csb[gi]) begin
        m_cnt <= 0;
      end else begin
        if (m_cnt < 32) m_hdr <= {m_hdr[30:0], io0_do[gi]};
        else if (io0_oeb[gi] !== 1'b1) m_oeb_bad <= m_oeb_bad + 1;
        m_cnt <= m_cnt + 1;
      end
    end

    // Flash drives data on SCK falling edges once the header is in.
    always @(negedge fclk[gi] or posedge csb[gi]) begin
      if (csb[gi]) m_do <= 1'b0;
      else if (m_cnt >= 32 && m_cnt < 64) m_do <= mem_bit(m_hdr[23:0], m_cnt - 32);
      else m_do <= 1'b0;
    end

    always @(posedge core_clk) begin
      if (rsp_valid[gi] === 1'b1) m_rsp <= m_rsp + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise the request and wait (bounded) until the cycle in which it is
  // accepted; returns at the negedge of that accept cycle.
  task automatic start_txn(input int i, input logic [23:0] a);
    int n;
    req_addr[i]  = a;
    req_valid[i] = 1'b1;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 50) begin
      @(negedge core_clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready[i]), 32'd1);
  endtask

  // From the accept-cycle negedge: count csb-low cycles and the cycle offset
  // of rsp_valid. Optional request pulses while busy.
  task automatic finish_txn(input int i, input bit pulses, output int rsp_k,
                            output int low_cnt, output logic [31:0] data);
    rsp_k   = -1;
    low_cnt = 0;
    data    = 'x;
    for (int k = 1; k <= 400; k++) begin
      @(negedge core_clk);
      if (k == 1) req_valid[i] = 1'b0;
      if (pulses && (k == 10 || k == 50 || k == 90)) begin
        chk("busy_ready", 32'(req_ready[i]), 32'd0);
        req_addr[i]  = 24'h000000;
        req_valid[i] = 1'b1;
      end
      if (pulses && (k == 11 || k == 51 || k == 91)) req_valid[i] = 1'b0;
      if (csb[i] === 1'b0) low_cnt++;
      if (rsp_valid[i] === 1'b1) begin
        rsp_k = k;
        data  = rsp_data[i];
        break;
      end
    end
    @(negedge core_clk);
    chk("rsp_pulse_width", 32'(rsp_valid[i]), 32'd0);
    chk("rsp_data_hold", rsp_data[i], data);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          rk;
    int          lc;
    int          r;
    int          acc2;
    bit          seen_low;
    logic [31:0] d;
    int unsigned rsp0;
    int unsigned rsp1;

    mem[24'h000100] = 8'h11;
    mem[24'h000101] = 8'h22;
    mem[24'h000102] = 8'h33;
    mem[24'h000103] = 8'h44;
    mem[24'h000000] = 8'hEF;
    mem[24'h000001] = 8'hBE;
    mem[24'h000002] = 8'hAD;
    mem[24'h000003] = 8'hDE;
    mem[24'hFFFFFF] = 8'h5A;

    core_rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
    end

    // Reset state
    repeat (3) @(negedge core_clk);
    chk("rst_csb",       32'(csb[0]),       32'd1);
    chk("rst_clk",       32'(fclk[0]),      32'd0);
    chk("rst_io0_do",    32'(io0_do[0]),    32'd0);
    chk("rst_io0_oeb",   32'(io0_oeb[0]),   32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_rsp_data",  rsp_data[0],       32'd0);
    core_rstn = 1'b1;
    @(negedge core_clk);
    chk("ready_after_rst", 32'(req_ready[0]), 32'd1);

    // Basic read, CLK_DIV=2
    start_txn(0, 24'h000100);
    finish_txn(0, 1'b0, rk, lc, d);
    $display("txn inst0 addr=000100 data=%h rsp_at=%0d csb_low=%0d", d, rk, lc);
    chk("a_data",    d,               32'h44332211);
    chk("a_rsp_at",  32'(rk),         32'd257);
    chk("a_csb_low", 32'(lc),         32'd256);
    chk("a_header",  g_inst[0].m_hdr, 32'h03000100);

    // CLK_DIV=1 read at address 0
    start_txn(1, 24'h000000);
    finish_txn(1, 1'b0, rk, lc, d);
    $display("txn inst1 addr=000000 data=%h rsp_at=%0d csb_low=%0d", d, rk, lc);
    chk("b_data",    d,               32'hDEADBEEF);
    chk("b_rsp_at",  32'(rk),         32'd129);
    chk("b_csb_low", 32'(lc),         32'd128);
    chk("b_header",  g_inst[1].m_hdr, 32'h03000000);

    // Back-to-back with req_valid held high
    rsp0 = g_inst[0].m_rsp;
    start_txn(0, 24'h000100);
    r = -1;
    acc2 = -1;
    seen_low = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge core_clk);
      if (csb[0] === 1'b0) seen_low = 1'b1;
      if (r < 0 && seen_low && csb[0] === 1'b1) r = k;
      if (r >= 0 && req_ready[0] === 1'b1) begin
        acc2 = k;
        break;
      end
    end
    $display("txn inst0 addr=000100 back-to-back first csb_rise=%0d second_accept=%0d", r, acc2);
    chk("c_first_data", rsp_data[0], 32'h44332211);
    chk("c_gap", 32'(acc2 - r), 32'(GAP));
    req_addr[0] = 24'h000101;
    finish_txn(0, 1'b0, rk, lc, d);
    $display("txn inst0 addr=000101 data=%h rsp_at=%0d csb_low=%0d", d, rk, lc);
    chk("c_second_data", d,                         32'h00443322);
    chk("c_rsp_count",   g_inst[0].m_rsp - rsp0,    32'd2);
    chk("c_oeb_in_data", g_inst[0].m_oeb_bad,       32'd0);

    // Reset in SCK period 40 of a CLK_DIV=2 transaction
    start_txn(0, 24'h000000);
    @(negedge core_clk);
    req_valid[0] = 1'b0;
    repeat (159) @(negedge core_clk);
    rsp0 = g_inst[0].m_rsp;
    chk("d_csb_before", 32'(csb[0]), 32'd0);
    core_rstn = 1'b0;
    #1;
    chk("d_csb",       32'(csb[0]),       32'd1);
    chk("d_clk",       32'(fclk[0]),      32'd0);
    chk("d_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("d_req_ready", 32'(req_ready[0]), 32'd0);
    chk("d_io0_oeb",   32'(io0_oeb[0]),   32'd1);
    chk("d_rsp_data",  rsp_data[0],       32'd0);
    repeat (3) @(negedge core_clk);
    core_rstn = 1'b1;
    @(negedge core_clk);
    chk("d_ready_release", 32'(req_ready[0]), 32'd1);
    repeat (10) @(negedge core_clk);
    chk("d_no_rsp", g_inst[0].m_rsp - rsp0, 32'd0);
    $display("txn inst0 addr=000000 aborted by reset");
    start_txn(0, 24'h000100);
    finish_txn(0, 1'b0, rk, lc, d);
    $display("txn inst0 addr=000100 data=%h rsp_at=%0d csb_low=%0d", d, rk, lc);
    chk("d_after_data",   d,       32'h44332211);
    chk("d_after_rsp_at", 32'(rk), 32'd257);

    // Top address: transmitted verbatim, model wraps its own read pointer
    start_txn(1, 24'hFFFFFF);
    finish_txn(1, 1'b0, rk, lc, d);
    $display("txn inst1 addr=ffffff data=%h rsp_at=%0d csb_low=%0d", d, rk, lc);
    chk("e_header", g_inst[1].m_hdr, 32'h03FFFFFF);
    chk("e_data",   d,               32'hADBEEF5A);

    // Request pulses while busy are dropped
    rsp1 = g_inst[1].m_rsp;
    start_txn(1, 24'h000100);
    finish_txn(1, 1'b1, rk, lc, d);
    $display("txn inst1 addr=000100 data=%h rsp_at=%0d (busy pulses)", d, rk);
    chk("f_data", d, 32'h44332211);
    repeat (10) @(negedge core_clk);
    chk("f_csb_idle",  32'(csb[1]),              32'd1);
    chk("f_rsp_count", g_inst[1].m_rsp - rsp1,   32'd1);
    chk("f_oeb_in_data", g_inst[1].m_oeb_bad,    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_spiflash_rd_ctrl
